// File: rtl/order_book_pkg.sv
// rtl/order_book_pkg.sv - shared order message layout, symbol table and scheduler state encoding
package order_book_pkg;

    localparam int MSG_W = 306;

    localparam int OFF_MSG_TYPE      = 0;
    localparam int OFF_SYMBOL_ID     = 1;
    localparam int OFF_SIDE          = 49;
    localparam int OFF_PRICE         = 50;
    localparam int OFF_ORIG_PRICE    = 114;
    localparam int OFF_QUANTITY      = 178;
    localparam int OFF_ORIG_ORDER_ID = 242;
    localparam int OFF_ORDER_ID      = 274;

    localparam logic [47:0] SYM_FOO  = 48'h0000_0046_4F4F;
    localparam logic [47:0] SYM_ABC  = 48'h0000_0041_4243;
    localparam logic [47:0] SYM_XYZ  = 48'h0000_0058_595A;
    localparam logic [47:0] SYM_BAR  = 48'h0000_0042_4152;
    localparam logic [47:0] SYM_MSFT = 48'h0000_4D53_4654;

    // Member order places msg_type at bit 0, matching the OFF_* offsets above.
    typedef struct packed {
        logic [31:0] order_id;
        logic [31:0] orig_order_id;
        logic [63:0] quantity;
        logic [63:0] orig_price;
        logic [63:0] price;
        logic        side;
        logic [47:0] symbol_id;
        logic        msg_type;
    } order_msg_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } sched_state_t;

    function automatic logic is_known_symbol(input logic [47:0] sym);
        return (sym == SYM_FOO) || (sym == SYM_ABC) || (sym == SYM_XYZ) ||
               (sym == SYM_BAR) || (sym == SYM_MSFT);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, first requester after last_grant wins
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic         hit;

    // Requesters above last_grant take priority; otherwise wrap to the lowest requester.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i > int'(last_grant));
        end
        masked    = req & mask;
        grant     = '0;
        grant_idx = '0;
        hit       = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!hit && masked[i]) begin
                grant[i]  = 1'b1;
                grant_idx = IW'(i);
                hit       = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!hit && req[i]) begin
                grant[i]  = 1'b1;
                grant_idx = IW'(i);
                hit       = 1'b1;
            end
        end
    end

    assign grant_any = |req;

endmodule

// File: rtl/order_msg_scheduler.sv
// rtl/order_msg_scheduler.sv - round-robin serialiser of feed-port order messages onto the order_book bus
module order_msg_scheduler
    import order_book_pkg::*;
#(
    parameter int NPORT      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [NPORT-1:0]       in_valid,
    output logic [NPORT-1:0]       in_ready,
    input  logic [NPORT*MSG_W-1:0] in_msg,
    output logic                   msg_valid,
    output logic                   msg_type,
    output logic [47:0]            symbol_id,
    output logic                   side,
    output logic [63:0]            price,
    output logic [63:0]            orig_price,
    output logic [63:0]            quantity,
    output logic [31:0]            orig_order_id,
    output logic [31:0]            order_id,
    output logic [2:0]             grant_port,
    output logic [31:0]            fwd_cnt,
    output logic [15:0]            drop_cnt
);

    localparam int         IW       = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [IW-1:0]    last_grant;
    logic [NPORT-1:0] arb_grant;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;
    logic [3:0]       gap_cnt;
    logic             accept;
    logic             sel_known;
    order_msg_t       sel_msg;
    order_msg_t       issued;

    rr_arbiter #(.N(NPORT)) u_arb (
        .req        (in_valid),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .grant_any  (arb_any)
    );

    always_comb begin
        sel_msg = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (arb_idx == IW'(p)) begin
                sel_msg = in_msg[p*MSG_W +: MSG_W];
            end
        end
        sel_known = is_known_symbol(sel_msg.symbol_id);
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        in_ready  = '0;
        case (state)
            ST_IDLE: begin
                if (en && arb_any) begin
                    accept   = 1'b1;
                    in_ready = arb_grant;
                    // Filtered messages never open a gap.
                    if (sel_known && (GAP_CYCLES > 0)) begin
                        state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt <= 4'd1) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (accept && sel_known) begin
            gap_cnt <= GAP_LOAD;
        end else if ((state == ST_GAP) && (gap_cnt != 4'd0)) begin
            gap_cnt <= gap_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IW'(NPORT - 1);
            grant_port <= '0;
            msg_valid  <= 1'b0;
            issued     <= '0;
            fwd_cnt    <= '0;
            drop_cnt   <= '0;
        end else begin
            msg_valid <= accept && sel_known;
            if (accept) begin
                last_grant <= arb_idx;
                grant_port <= 3'(arb_idx);
                if (sel_known) begin
                    issued  <= sel_msg;
                    fwd_cnt <= fwd_cnt + 32'd1;
                end else if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

    assign msg_type      = issued.msg_type;
    assign symbol_id     = issued.symbol_id;
    assign side          = issued.side;
    assign price         = issued.price;
    assign orig_price    = issued.orig_price;
    assign quantity      = issued.quantity;
    assign orig_order_id = issued.orig_order_id;
    assign order_id      = issued.order_id;

endmodule

// File: tb/tb_order_msg_scheduler.sv
// tb/tb_order_msg_scheduler.sv - self-checking bench for order_msg_scheduler (GAP_CYCLES 2 and 0)
module tb_order_msg_scheduler;
    import order_book_pkg::*;

    localparam int NP = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [NP-1:0]     in_valid;
    logic [NP*MSG_W-1:0] in_msg;
    logic              sel;

    logic [NP-1:0] a_rdy, b_rdy;
    logic          a_mv, b_mv, a_mt, b_mt, a_side, b_side;
    logic [47:0]   a_sym, b_sym;
    logic [63:0]   a_price, b_price, a_oprice, b_oprice, a_qty, b_qty;
    logic [31:0]   a_ooid, b_ooid, a_oid, b_oid, a_fwd, b_fwd;
    logic [2:0]    a_gp, b_gp;
    logic [15:0]   a_drop, b_drop;

    logic [NP-1:0] rdy;
    logic          mv;
    order_msg_t    omsg;
    logic [2:0]    gp;
    logic [31:0]   fwd;
    logic [15:0]   drop;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int          acc_q[$];
    int          acc_c[$];
    int          mv_c[$];
    logic [47:0] mv_sym[$];

    logic [47:0] known_tab [5];

    always #5 clk = ~clk;

    order_msg_scheduler #(.NPORT(NP), .GAP_CYCLES(2)) dut_g2 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(a_rdy), .in_msg(in_msg),
        .msg_valid(a_mv), .msg_type(a_mt), .symbol_id(a_sym), .side(a_side), .price(a_price),
        .orig_price(a_oprice), .quantity(a_qty), .orig_order_id(a_ooid), .order_id(a_oid),
        .grant_port(a_gp), .fwd_cnt(a_fwd), .drop_cnt(a_drop)
    );

    order_msg_scheduler #(.NPORT(NP), .GAP_CYCLES(0)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(b_rdy), .in_msg(in_msg),
        .msg_valid(b_mv), .msg_type(b_mt), .symbol_id(b_sym), .side(b_side), .price(b_price),
        .orig_price(b_oprice), .quantity(b_qty), .orig_order_id(b_ooid), .order_id(b_oid),
        .grant_port(b_gp), .fwd_cnt(b_fwd), .drop_cnt(b_drop)
    );

    always_comb begin
        if (sel) begin
            rdy  = b_rdy; mv = b_mv; gp = b_gp; fwd = b_fwd; drop = b_drop;
            omsg = {b_oid, b_ooid, b_qty, b_oprice, b_price, b_side, b_sym, b_mt};
        end else begin
            rdy  = a_rdy; mv = a_mv; gp = a_gp; fwd = a_fwd; drop = a_drop;
            omsg = {a_oid, a_ooid, a_qty, a_oprice, a_price, a_side, a_sym, a_mt};
        end
    end

    task automatic chk(input string name, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic order_msg_t mk(input logic [47:0] sym, input logic [63:0] pr,
                                      input logic [63:0] qty, input logic [31:0] id);
        order_msg_t m;
        m = '0;
        m.symbol_id = sym;
        m.price     = pr;
        m.quantity  = qty;
        m.order_id  = id;
        return m;
    endfunction

    function automatic order_msg_t rand_msg();
        order_msg_t m;
        m.msg_type      = 1'($urandom);
        m.side          = 1'($urandom);
        m.price         = {$urandom, $urandom};
        m.orig_price    = {$urandom, $urandom};
        m.quantity      = {$urandom, $urandom};
        m.orig_order_id = $urandom;
        m.order_id      = $urandom;
        if ($urandom_range(3, 0) != 0) m.symbol_id = known_tab[$urandom_range(4, 0)];
        else                            m.symbol_id = {$urandom, $urandom};
        return m;
    endfunction

    function automatic bit is_listed(input logic [47:0] s);
        foreach (known_tab[i]) if (known_tab[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int idx_of(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_msg(input int p, input order_msg_t m);
        in_msg[p*MSG_W +: MSG_W] = m;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        in_valid = '0;
        en       = 1'b1;
        rst_n    = 1'b0;
        @(negedge clk);
        chk("rst_msg_valid", MSG_W'(mv), '0);
        chk("rst_fields", omsg, '0);
        chk("rst_counters", MSG_W'({fwd, drop, gp}), '0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic clear_q();
        acc_q.delete(); acc_c.delete(); mv_c.delete(); mv_sym.delete();
    endtask

    task automatic run_src(input int ncyc);
        logic [NP-1:0] grab;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            chk("ready_onehot0", MSG_W'($onehot0(rdy)), MSG_W'(1));
            if (rdy != '0) begin
                acc_q.push_back(idx_of(rdy));
                acc_c.push_back(cyc);
            end
            if (mv) begin
                mv_c.push_back(cyc);
                mv_sym.push_back(omsg.symbol_id);
            end
            grab = rdy;
            step();
            in_valid = in_valid & ~grab;
        end
    endtask

    typedef struct {
        int          port;
        logic [47:0] sym;
        logic [63:0] price;
        logic [63:0] qty;
        logic [31:0] id;
        bit          exp_issue;
    } vec_t;

    task automatic random_run(input int gap, input int ncyc);
        order_msg_t    cur [NP];
        bit            has [NP];
        order_msg_t    exp_msg;
        bit            exp_mv;
        int            last, next_ok, g, e_gp;
        int            e_fwd, e_drop;
        logic [NP-1:0] exp_rdy;
        do_reset();
        last = NP - 1; next_ok = 0; exp_mv = 0; exp_msg = '0;
        e_fwd = 0; e_drop = 0; e_gp = 0;
        foreach (has[p]) has[p] = 0;
        for (int c = 0; c < ncyc; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!has[p] && $urandom_range(2, 0) == 0) begin
                    cur[p] = rand_msg();
                    has[p] = 1;
                end
                in_valid[p] = has[p];
                set_msg(p, cur[p]);
            end
            en = ($urandom_range(7, 0) != 0);
            @(negedge clk);
            g = -1;
            if (en && cyc >= next_ok) begin
                for (int k = 1; k <= NP; k++) begin
                    if (g < 0 && has[(last + k) % NP]) g = (last + k) % NP;
                end
            end
            exp_rdy = (g >= 0) ? NP'(1 << g) : '0;
            chk("rnd_in_ready", MSG_W'(rdy), MSG_W'(exp_rdy));
            chk("rnd_msg_valid", MSG_W'(mv), MSG_W'(exp_mv));
            if (exp_mv) chk("rnd_fields", omsg, exp_msg);
            chk("rnd_fwd_cnt", MSG_W'(fwd), MSG_W'(e_fwd));
            chk("rnd_drop_cnt", MSG_W'(drop), MSG_W'(e_drop));
            chk("rnd_grant_port", MSG_W'(gp), MSG_W'(e_gp));
            exp_mv = 0;
            if (g >= 0) begin
                last = g; e_gp = g; has[g] = 0;
                if (is_listed(cur[g].symbol_id)) begin
                    exp_mv  = 1;
                    exp_msg = cur[g];
                    e_fwd++;
                    next_ok = cyc + gap + 1;
                end else if (e_drop < 16'hFFFF) begin
                    e_drop++;
                end
            end
            step();
        end
        in_valid = '0;
    endtask

    initial begin
        vec_t vt [8];
        int   e_fwd, e_drop, n2;

        known_tab[0] = 48'h464F4F;   known_tab[1] = 48'h414243; known_tab[2] = 48'h58595A;
        known_tab[3] = 48'h424152;   known_tab[4] = 48'h4D534654;

        vt[0] = '{0, 48'h414243,     64'd100, 64'd10, 32'd1, 1'b1};
        vt[1] = '{2, 48'h4D534654,   64'd5000, 64'd3, 32'd2, 1'b1};
        vt[2] = '{1, 48'h444546,     64'd7, 64'd1, 32'd3, 1'b0};
        vt[3] = '{3, 48'h464F4F,     64'd1, 64'd1, 32'd4, 1'b1};
        vt[4] = '{0, 48'h414244,     64'd9, 64'd9, 32'd5, 1'b0};
        vt[5] = '{2, 48'h58595A,     64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'd6, 1'b1};
        vt[6] = '{1, 48'h424152,     64'd0, 64'd0, 32'd7, 1'b1};
        vt[7] = '{3, 48'hFFFF_FF414243, 64'd8, 64'd8, 32'd8, 1'b0};

        sel = 1'b0; in_msg = '0; in_valid = '0; en = 1'b1; rst_n = 1'b0;
        do_reset();

        e_fwd = 0; e_drop = 0;
        for (int i = 0; i < 8; i++) begin
            set_msg(vt[i].port, mk(vt[i].sym, vt[i].price, vt[i].qty, vt[i].id));
            in_valid = NP'(1 << vt[i].port);
            @(negedge clk);
            chk("vec_in_ready", MSG_W'(rdy), MSG_W'(1 << vt[i].port));
            step();
            in_valid = '0;
            if (vt[i].exp_issue) e_fwd++; else e_drop++;
            @(negedge clk);
            chk("vec_msg_valid", MSG_W'(mv), MSG_W'(vt[i].exp_issue));
            if (vt[i].exp_issue) begin
                chk("vec_symbol", MSG_W'(omsg.symbol_id), MSG_W'(vt[i].sym));
                chk("vec_price", MSG_W'(omsg.price), MSG_W'(vt[i].price));
            end
            chk("vec_fwd_cnt", MSG_W'(fwd), MSG_W'(e_fwd));
            chk("vec_drop_cnt", MSG_W'(drop), MSG_W'(e_drop));
            chk("vec_grant_port", MSG_W'(gp), MSG_W'(vt[i].port));
            for (int k = 0; k < 3; k++) step();
        end

        // all four ports at once: rotation 0..3, pulses GAP+1 apart
        do_reset(); clear_q();
        for (int p = 0; p < NP; p++) set_msg(p, mk(known_tab[p], 64'(p + 10), 64'd1, 32'(p)));
        in_valid = '1;
        run_src(16);
        chk("rr_accept_count", MSG_W'(acc_q.size()), MSG_W'(4));
        chk("rr_issue_count", MSG_W'(mv_c.size()), MSG_W'(4));
        for (int i = 0; i < acc_q.size() && i < 4; i++) chk("rr_order", MSG_W'(acc_q[i]), MSG_W'(i));
        for (int i = 1; i < mv_c.size(); i++) chk("rr_spacing", MSG_W'(mv_c[i] - mv_c[i-1]), MSG_W'(3));

        // filtered symbol: no pulse, no gap
        do_reset(); clear_q();
        set_msg(1, mk(48'h444546, 64'd1, 64'd1, 32'd1));
        set_msg(2, mk(48'h58595A, 64'd2, 64'd2, 32'd2));
        in_valid = 4'b0110;
        run_src(6);
        chk("drop_accept_count", MSG_W'(acc_q.size()), MSG_W'(2));
        if (acc_q.size() == 2) begin
            chk("drop_first_port", MSG_W'(acc_q[0]), MSG_W'(1));
            chk("drop_next_cycle", MSG_W'(acc_c[1] - acc_c[0]), MSG_W'(1));
        end
        chk("drop_issue_count", MSG_W'(mv_c.size()), MSG_W'(1));
        chk("drop_cnt_one", MSG_W'(drop), MSG_W'(1));
        chk("drop_fwd_one", MSG_W'(fwd), MSG_W'(1));

        // GAP_CYCLES=0 streaming from port 3
        sel = 1'b1;
        do_reset();
        for (int k = 0; k <= 5; k++) begin
            if (k < 5) begin
                set_msg(3, mk(48'h414243, 64'(k + 50), 64'd1, 32'(k)));
                in_valid = 4'b1000;
            end else begin
                in_valid = '0;
            end
            @(negedge clk);
            if (k < 5) chk("stream_ready", MSG_W'(rdy), MSG_W'(4'b1000));
            if (k > 0) begin
                chk("stream_msg_valid", MSG_W'(mv), MSG_W'(1));
                chk("stream_price", MSG_W'(omsg.price), MSG_W'(k + 49));
            end
            step();
        end
        @(negedge clk);
        chk("stream_idle_after", MSG_W'(mv), MSG_W'(0));
        chk("stream_fwd_cnt", MSG_W'(fwd), MSG_W'(5));
        chk("stream_grant_port", MSG_W'(gp), MSG_W'(3));
        step();
        sel = 1'b0;

        // en gating, including en falling mid-gap
        do_reset();
        en = 1'b0;
        set_msg(0, mk(48'h414243, 64'd1, 64'd1, 32'd1));
        set_msg(1, mk(48'h424152, 64'd2, 64'd2, 32'd2));
        in_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("en0_no_ready", MSG_W'(rdy), '0);
            step();
        end
        en = 1'b1;
        @(negedge clk);
        chk("en_rise_grant", MSG_W'(rdy), MSG_W'(4'b0001));
        step();
        in_valid = 4'b0010;
        en = 1'b0;
        @(negedge clk);
        chk("en_gap_issue", MSG_W'(mv), MSG_W'(1));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("en0_after_gap", MSG_W'(rdy), '0);
            step();
        end
        en = 1'b1;
        @(negedge clk);
        chk("en_regrant", MSG_W'(rdy), MSG_W'(4'b0010));
        step();
        in_valid = '0;
        for (int k = 0; k < 3; k++) step();

        // reset while in GAP with requests held
        do_reset(); clear_q();
        set_msg(1, mk(48'h464F4F, 64'd11, 64'd1, 32'd1));
        in_valid = 4'b0010;
        @(negedge clk);
        chk("rg_first_ready", MSG_W'(rdy), MSG_W'(4'b0010));
        step();
        set_msg(0, mk(48'h424152, 64'd20, 64'd1, 32'd2));
        set_msg(2, mk(48'h58595A, 64'd22, 64'd1, 32'd3));
        in_valid = 4'b0101;
        @(negedge clk);
        chk("rg_gap_no_ready", MSG_W'(rdy), '0);
        chk("rg_gap_issue", MSG_W'(mv), MSG_W'(1));
        rst_n = 1'b0;
        #1;
        chk("rg_async_mv", MSG_W'(mv), '0);
        chk("rg_async_fields", omsg, '0);
        chk("rg_async_fwd", MSG_W'(fwd), '0);
        step();
        rst_n = 1'b1;
        run_src(10);
        chk("rg_accept_count", MSG_W'(acc_q.size()), MSG_W'(2));
        if (acc_q.size() == 2) begin
            chk("rg_port0_first", MSG_W'(acc_q[0]), MSG_W'(0));
            chk("rg_port2_second", MSG_W'(acc_q[1]), MSG_W'(2));
        end
        n2 = 0;
        foreach (mv_sym[i]) if (mv_sym[i] == 48'h58595A) n2++;
        chk("rg_port2_once", MSG_W'(n2), MSG_W'(1));

        sel = 1'b0;
        random_run(2, 1500);
        sel = 1'b1;
        random_run(0, 1500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
